// File: rtl/system_pio_pkg.sv
// Shared constants for the interrupt-capable input PIO: register word addresses
// and the debounce counter sizing helper.
package system_pio_pkg;

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_RISE = 3'd1;
    localparam logic [2:0] ADDR_MASK = 3'd2;
    localparam logic [2:0] ADDR_CAP  = 3'd3;
    localparam logic [2:0] ADDR_FALL = 3'd4;

    // Counter only has to reach n-1, so clog2(n) bits suffice (minimum 1).
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/system_pio_debounce.sv
// One-bit glitch filter: the output follows the input only after the input has
// disagreed with it for DEBOUNCE_CYCLES consecutive clocks.
module system_pio_debounce
    import system_pio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (din != dout) begin
            if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                dout <= din;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            // Any reversion restarts the stability window.
            cnt <= '0;
        end
    end

endmodule

// File: rtl/system_pio_irq_in.sv
// Avalon-MM input PIO with per-bit rise/fall edge capture and level irq.
// Optional glitch filter enabled by defining PIO_DEBOUNCE_EN.
module system_pio_irq_in
    import system_pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] synced, f, f_d;
    logic [WIDTH-1:0] rise_en, fall_en, irq_mask, edge_cap;
    logic [WIDTH-1:0] edge_evt, cap_clr, wd;
    logic [31:0]      rd_mux;
    logic             wr;
    logic             unused_bits;

    assign unused_bits = ^{writedata, DEBOUNCE_CYCLES};

    assign wr     = chipselect & ~write_n;
    assign wd     = writedata[WIDTH-1:0];
    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
    end

`ifdef PIO_DEBOUNCE_EN
    for (genvar i = 0; i < WIDTH; i++) begin : g_deb
        system_pio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk    (clk),
            .reset_n(reset_n),
            .din    (synced[i]),
            .dout   (f[i])
        );
    end
`else
    assign f = synced;
`endif

    assign edge_evt = (f & ~f_d & rise_en) | (~f & f_d & fall_en);
    assign cap_clr  = (wr && address == ADDR_CAP) ? wd : '0;
    assign irq      = |(edge_cap & irq_mask);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_d      <= '0;
            rise_en  <= '0;
            fall_en  <= '0;
            irq_mask <= '0;
            edge_cap <= '0;
        end else begin
            f_d <= f;
            if (wr && address == ADDR_RISE) rise_en  <= wd;
            if (wr && address == ADDR_MASK) irq_mask <= wd;
            if (wr && address == ADDR_FALL) fall_en  <= wd;
            // Set is OR'd in after the clear so a coincident event survives.
            edge_cap <= (edge_cap & ~cap_clr) | edge_evt;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA: rd_mux[WIDTH-1:0] = f;
            ADDR_RISE: rd_mux[WIDTH-1:0] = rise_en;
            ADDR_MASK: rd_mux[WIDTH-1:0] = irq_mask;
            ADDR_CAP:  rd_mux[WIDTH-1:0] = edge_cap;
            ADDR_FALL: rd_mux[WIDTH-1:0] = fall_en;
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_mux;
    end

endmodule
